// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store sequencer.
package lsu_pkg;

    typedef enum logic [2:0] {
        LT_B  = 3'b000,
        LT_H  = 3'b001,
        LT_W  = 3'b010,
        LT_BU = 3'b100,
        LT_HU = 3'b101
    } lsu_type_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ0,
        REQ1,
        RESP
    } lsu_state_e;

    // Access size in bytes from the funct3 width bits.
    function automatic logic [2:0] lsu_size(input logic [2:0] ltype);
        case (ltype[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Width 11 has no meaning here; stores have no unsigned forms.
    function automatic logic lsu_illegal(input logic we, input logic [2:0] ltype);
        return (ltype[1:0] == 2'b11) || (we && ltype[2]) || (ltype == 3'b110);
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core-side request/response bundle and word-memory bus bundle.
interface lsu_core_if;
    logic        lsu_valid;
    logic        lsu_ready;
    logic        lsu_we;
    logic [2:0]  lsu_type;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic        lsu_misalign;

    modport master (
        output lsu_valid, lsu_we, lsu_type, lsu_addr, lsu_wdata,
        input  lsu_ready, lsu_done, lsu_rdata, lsu_err, lsu_misalign
    );
    modport slave (
        input  lsu_valid, lsu_we, lsu_type, lsu_addr, lsu_wdata,
        output lsu_ready, lsu_done, lsu_rdata, lsu_err, lsu_misalign
    );
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Shifts the two-word read window down by the byte offset and extends per load type.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] data,
    input  logic [1:0]  off,
    input  logic [2:0]  ltype,
    output logic [31:0] rdata
);
    logic [31:0] raw;

    assign raw = 32'(data >> {off, 3'b000});

    always_comb begin
        rdata = raw;
        case (ltype)
            LT_B:    rdata = {{24{raw[7]}}, raw[7:0]};
            LT_H:    rdata = {{16{raw[15]}}, raw[15:0]};
            LT_BU:   rdata = {24'd0, raw[7:0]};
            LT_HU:   rdata = {16'd0, raw[15:0]};
            default: rdata = raw;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: one access at a time onto a word memory with req/ready,
// optional split of word-crossing accesses, per-transaction timeout.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int SPLIT_MISALIGNED = 1,
    parameter int TIMEOUT          = 64,
    parameter int TO_W             = 7
) (
    input  logic      clk,
    input  logic      reset,
    lsu_core_if.slave core,
    lsu_mem_if.master mem
);
    // state | meaning
    // IDLE  | waiting for a request, lsu_ready high
    // REQ0  | first (or only) word transaction on the memory bus
    // REQ1  | upper word of a word-crossing access
    // RESP  | one-cycle done pulse with data / error flags

    localparam logic [TO_W-1:0] TO_LOAD = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

    lsu_state_e state_q, state_d;

    logic            we_q;
    logic [2:0]      type_q;
    logic [1:0]      off_q;
    logic [29:0]     wa_q;
    logic [7:0]      be8_q;
    logic [63:0]     wd64_q;
    logic            split_q;
    logic [31:0]     lo_q, hi_q;
    logic            err_q, err_d, mis_q, mis_d;
    logic [TO_W-1:0] to_cnt;

    logic        accept, illegal_c, split_c, misrej_c;
    logic        lo_en, hi_en, to_hit, in_req;
    logic [2:0]  size_c;
    logic [7:0]  mask_c, be8_c;
    logic [63:0] wd64_c;
    logic [31:0] ld_data;

    assign size_c    = lsu_size(core.lsu_type);
    assign mask_c    = (8'd1 << size_c) - 8'd1;
    assign be8_c     = mask_c << core.lsu_addr[1:0];
    assign wd64_c    = {32'd0, core.lsu_wdata} << {core.lsu_addr[1:0], 3'b000};
    assign split_c   = |be8_c[7:4];
    assign illegal_c = lsu_illegal(core.lsu_we, core.lsu_type);
    assign misrej_c  = split_c && (SPLIT_MISALIGNED == 0);
    assign accept    = (state_q == IDLE) && core.lsu_valid;
    assign in_req    = (state_q == REQ0) || (state_q == REQ1);
    assign to_hit    = (TIMEOUT > 0) && (to_cnt == '0);

    lsu_load_align u_align (
        .data  ({hi_q, lo_q}),
        .off   (off_q),
        .ltype (type_q),
        .rdata (ld_data)
    );

    always_comb begin
        state_d           = state_q;
        err_d             = err_q;
        mis_d             = mis_q;
        lo_en             = 1'b0;
        hi_en             = 1'b0;
        core.lsu_ready    = 1'b0;
        core.lsu_done     = 1'b0;
        core.lsu_rdata    = '0;
        core.lsu_err      = 1'b0;
        core.lsu_misalign = 1'b0;
        mem.mem_req       = 1'b0;
        mem.mem_we        = 1'b0;
        mem.mem_addr      = '0;
        mem.mem_be        = '0;
        mem.mem_wdata     = '0;
        case (state_q)
            IDLE: begin
                core.lsu_ready = 1'b1;
                if (core.lsu_valid) begin
                    err_d   = illegal_c;
                    mis_d   = !illegal_c && misrej_c;
                    state_d = (illegal_c || misrej_c) ? RESP : REQ0;
                end
            end
            REQ0: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = we_q;
                mem.mem_addr  = {wa_q, 2'b00};
                mem.mem_be    = be8_q[3:0];
                mem.mem_wdata = wd64_q[31:0];
                if (mem.mem_ready) begin
                    lo_en   = 1'b1;
                    state_d = split_q ? REQ1 : RESP;
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            REQ1: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = we_q;
                mem.mem_addr  = {wa_q + 30'd1, 2'b00};
                mem.mem_be    = be8_q[7:4];
                mem.mem_wdata = wd64_q[63:32];
                if (mem.mem_ready) begin
                    hi_en   = 1'b1;
                    state_d = RESP;
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                core.lsu_done     = 1'b1;
                core.lsu_err      = err_q;
                core.lsu_misalign = mis_q;
                core.lsu_rdata    = (err_q || mis_q || we_q) ? '0 : ld_data;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            type_q  <= '0;
            off_q   <= '0;
            wa_q    <= '0;
            be8_q   <= '0;
            wd64_q  <= '0;
            split_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            to_cnt  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
            if (accept) begin
                we_q    <= core.lsu_we;
                type_q  <= core.lsu_type;
                off_q   <= core.lsu_addr[1:0];
                wa_q    <= core.lsu_addr[31:2];
                be8_q   <= be8_c;
                wd64_q  <= wd64_c;
                split_q <= split_c;
                lo_q    <= '0;
                hi_q    <= '0;
            end
            if (lo_en) lo_q <= mem.mem_rdata;
            if (hi_en) hi_q <= mem.mem_rdata;
            // Reloaded on every entry into a request state, so each word gets its own budget.
            if (state_d != state_q)
                to_cnt <= (state_d == REQ0 || state_d == REQ1) ? TO_LOAD : '0;
            else if (in_req && !mem.mem_ready && to_cnt != '0)
                to_cnt <= to_cnt - TO_W'(1);
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: one split-enabled instance and one rejecting misaligned accesses.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] wmask;
    } mem_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        mis;
        int          lat;
    } resp_exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lsu_core_if core ();
    lsu_mem_if  mem ();
    lsu_core_if core_ns ();
    lsu_mem_if  mem_ns ();

    lsu_mem_ctrl #(.SPLIT_MISALIGNED(1), .TIMEOUT(4), .TO_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .core  (core),
        .mem   (mem)
    );

    lsu_mem_ctrl #(.SPLIT_MISALIGNED(0), .TIMEOUT(4), .TO_W(3)) dut_ns (
        .clk   (clk),
        .reset (reset),
        .core  (core_ns),
        .mem   (mem_ns)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rdy_budget = -1;
    int req_cycles = 0;
    int ns_req_cycles = 0;
    int n_done = 0;

    logic [31:0] mem_arr [logic [31:0]];
    mem_exp_t    mem_q[$];
    resp_exp_t   resp_q[$];
    mem_exp_t    me;
    resp_exp_t   re;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responders and scoreboard monitor; DUT outputs are stable at negedge.
    always @(negedge clk) begin
        mem.mem_ready = mem.mem_req && (rdy_budget != 0);
        mem.mem_rdata = (mem.mem_req && mem_arr.exists(mem.mem_addr)) ? mem_arr[mem.mem_addr] : 32'h0;
        if (mem.mem_req) req_cycles++;
        if (mem.mem_ready) begin
            if (rdy_budget > 0) rdy_budget--;
            chk("mem_txn_expected", 32'(mem_q.size() != 0), 32'd1);
            if (mem_q.size() != 0) begin
                me = mem_q.pop_front();
                chk("mem_addr", mem.mem_addr, me.addr);
                chk("mem_be", 32'(mem.mem_be), 32'(me.be));
                chk("mem_we", 32'(mem.mem_we), 32'(me.we));
                chk("mem_wdata", mem.mem_wdata & me.wmask, me.wdata & me.wmask);
            end
        end
        if (core.lsu_done) begin
            n_done++;
            chk("resp_expected", 32'(resp_q.size() != 0), 32'd1);
            if (resp_q.size() != 0) begin
                re = resp_q.pop_front();
                chk("lsu_rdata", core.lsu_rdata, re.rdata);
                chk("lsu_err", 32'(core.lsu_err), 32'(re.err));
                chk("lsu_misalign", 32'(core.lsu_misalign), 32'(re.mis));
                chk("done_latency", 32'(cyc - acc_cyc), 32'(re.lat));
            end
        end
        mem_ns.mem_ready = mem_ns.mem_req;
        mem_ns.mem_rdata = 32'hCAFEF00D;
        if (mem_ns.mem_req) ns_req_cycles++;
    end

    task automatic issue(input logic we, input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd);
        int k;
        k = 0;
        @(negedge clk);
        while (!core.lsu_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("ready_before_issue", 32'(core.lsu_ready), 32'd1);
        core.lsu_valid = 1'b1;
        core.lsu_we    = we;
        core.lsu_type  = t;
        core.lsu_addr  = a;
        core.lsu_wdata = wd;
        acc_cyc        = cyc;
        @(posedge clk);
        #1 core.lsu_valid = 1'b0;
    endtask

    task automatic wait_done();
        int d0;
        int k;
        d0 = n_done;
        k = 0;
        while (n_done == d0 && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("done_seen", 32'(n_done != d0), 32'd1);
    endtask

    task automatic ns_access(input string tag, input logic [2:0] t, input logic [31:0] a,
                             input logic [31:0] exp_rd, input logic exp_mis);
        int c0;
        int k;
        @(negedge clk);
        chk({tag, "_ready"}, 32'(core_ns.lsu_ready), 32'd1);
        core_ns.lsu_valid = 1'b1;
        core_ns.lsu_we    = 1'b0;
        core_ns.lsu_type  = t;
        core_ns.lsu_addr  = a;
        core_ns.lsu_wdata = 32'h0;
        c0 = cyc;
        @(posedge clk);
        #1 core_ns.lsu_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!core_ns.lsu_done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"}, 32'(core_ns.lsu_done), 32'd1);
        chk({tag, "_lat"}, 32'(cyc - c0), exp_mis ? 32'd1 : 32'd2);
        chk({tag, "_rdata"}, core_ns.lsu_rdata, exp_rd);
        chk({tag, "_mis"}, 32'(core_ns.lsu_misalign), 32'(exp_mis));
        chk({tag, "_err"}, 32'(core_ns.lsu_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        reset = 1'b1;
        core.lsu_valid = 1'b0; core.lsu_we = 1'b0; core.lsu_type = '0;
        core.lsu_addr = '0;    core.lsu_wdata = '0;
        core_ns.lsu_valid = 1'b0; core_ns.lsu_we = 1'b0; core_ns.lsu_type = '0;
        core_ns.lsu_addr = '0;    core_ns.lsu_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_ready", 32'(core.lsu_ready), 32'd1);
        chk("rst_done", 32'(core.lsu_done), 32'd0);
        chk("rst_rdata", core.lsu_rdata, 32'd0);
        chk("rst_err", 32'(core.lsu_err), 32'd0);
        chk("rst_mem_req", 32'(mem.mem_req), 32'd0);
        chk("rst_mem_addr", mem.mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem.mem_be), 32'd0);

        // Aligned word load
        mem_arr[32'h100] = 32'hDEADBEEF;
        mem_q.push_back('{32'h100, 4'b1111, 1'b0, 32'h0, 32'h0});
        resp_q.push_back('{32'hDEADBEEF, 1'b0, 1'b0, 2});
        issue(1'b0, LT_W, 32'h100, 32'h0);
        wait_done();

        // Byte and halfword loads, signed and unsigned
        mem_arr[32'h100] = 32'h80FFFFFF;
        mem_q.push_back('{32'h100, 4'b1000, 1'b0, 32'h0, 32'h0});
        resp_q.push_back('{32'hFFFFFF80, 1'b0, 1'b0, 2});
        issue(1'b0, LT_B, 32'h103, 32'h0);
        wait_done();
        mem_q.push_back('{32'h100, 4'b1000, 1'b0, 32'h0, 32'h0});
        resp_q.push_back('{32'h00000080, 1'b0, 1'b0, 2});
        issue(1'b0, LT_BU, 32'h103, 32'h0);
        wait_done();
        mem_q.push_back('{32'h100, 4'b1100, 1'b0, 32'h0, 32'h0});
        resp_q.push_back('{32'hFFFF80FF, 1'b0, 1'b0, 2});
        issue(1'b0, LT_H, 32'h102, 32'h0);
        wait_done();
        mem_q.push_back('{32'h100, 4'b1100, 1'b0, 32'h0, 32'h0});
        resp_q.push_back('{32'h000080FF, 1'b0, 1'b0, 2});
        issue(1'b0, LT_HU, 32'h102, 32'h0);
        wait_done();

        // Halfword store in the upper lanes
        mem_q.push_back('{32'h200, 4'b1100, 1'b1, 32'hABCD0000, 32'hFFFF0000});
        resp_q.push_back('{32'h0, 1'b0, 1'b0, 2});
        issue(1'b1, LT_H, 32'h202, 32'h1234ABCD);
        wait_done();

        // Split word load across 0x300/0x304
        mem_arr[32'h300] = 32'h332211FF;
        mem_arr[32'h304] = 32'h77776644;
        mem_q.push_back('{32'h300, 4'b1110, 1'b0, 32'h0, 32'h0});
        mem_q.push_back('{32'h304, 4'b0001, 1'b0, 32'h0, 32'h0});
        resp_q.push_back('{32'h44332211, 1'b0, 1'b0, 3});
        issue(1'b0, LT_W, 32'h301, 32'h0);
        wait_done();

        // Split halfword store wrapping the top of the address space
        mem_q.push_back('{32'hFFFFFFFC, 4'b1000, 1'b1, 32'hEF000000, 32'hFF000000});
        mem_q.push_back('{32'h00000000, 4'b0001, 1'b1, 32'h000000BE, 32'h000000FF});
        resp_q.push_back('{32'h0, 1'b0, 1'b0, 3});
        issue(1'b1, LT_H, 32'hFFFFFFFF, 32'h0000BEEF);
        wait_done();

        // Illegal types: no memory access, error one cycle after accept
        resp_q.push_back('{32'h0, 1'b1, 1'b0, 1});
        issue(1'b0, 3'b011, 32'h100, 32'h0);
        wait_done();
        resp_q.push_back('{32'h0, 1'b1, 1'b0, 1});
        issue(1'b1, 3'b100, 32'h100, 32'h000000FF);
        wait_done();
        resp_q.push_back('{32'h0, 1'b1, 1'b0, 1});
        issue(1'b0, 3'b110, 32'h100, 32'h0);
        wait_done();

        // Timeout: memory never answers
        rdy_budget = 0;
        req_cycles = 0;
        resp_q.push_back('{32'h0, 1'b1, 1'b0, 5});
        issue(1'b0, LT_W, 32'h400, 32'h0);
        wait_done();
        chk("timeout_req_cycles", 32'(req_cycles), 32'd4);
        rdy_budget = -1;

        // Reset while the second word of a split access is pending
        rdy_budget = 1;
        mem_q.push_back('{32'h300, 4'b1110, 1'b0, 32'h0, 32'h0});
        issue(1'b0, LT_W, 32'h301, 32'h0);
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        chk("abort_req1_active", 32'(mem.mem_req), 32'd1);
        chk("abort_req1_addr", mem.mem_addr, 32'h304);
        d0 = n_done;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_mem_req", 32'(mem.mem_req), 32'd0);
        chk("abort_ready", 32'(core.lsu_ready), 32'd1);
        reset = 1'b0;
        rdy_budget = -1;
        repeat (4) @(negedge clk);
        #1;
        chk("abort_no_done", 32'(n_done), 32'(d0));

        // Misaligned rejection when splitting is disabled
        ns_req_cycles = 0;
        ns_access("ns_mis", LT_W, 32'h301, 32'h0, 1'b1);
        chk("ns_no_mem_req", 32'(ns_req_cycles), 32'd0);
        ns_access("ns_aligned", LT_W, 32'h100, 32'hCAFEF00D, 1'b0);

        chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
        chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
